// File: rtl/fun_dispatch_if.sv
// fun_dispatch_if: groups the three handshakes around fun_dispatch.
//   in_*   operand pairs from a valid/ready source
//   fun_*  start/busy link to the fun core (result = a * cbrt(b))
//   out_*  results with per-op cycle count and error flag to a valid/ready sink
// Modports:
//   slave  - the dispatcher's view (fun_dispatch)
//   master - the surrounding environment (source, fun core, sink)
// Parameter CNT_W must match the dispatcher's CNT_W.
interface fun_dispatch_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_a;
  logic [7:0]       in_b;
  logic [7:0]       fun_a;
  logic [7:0]       fun_b;
  logic             fun_start;
  logic             fun_busy;
  logic [10:0]      fun_result;
  logic             out_valid;
  logic             out_ready;
  logic [10:0]      out_result;
  logic [CNT_W-1:0] out_cycles;
  logic             out_err;

  modport slave (
    input  in_valid, in_a, in_b, fun_busy, fun_result, out_ready,
    output in_ready, fun_a, fun_b, fun_start, out_valid, out_result, out_cycles, out_err
  );

  modport master (
    output in_valid, in_a, in_b, fun_busy, fun_result, out_ready,
    input  in_ready, fun_a, fun_b, fun_start, out_valid, out_result, out_cycles, out_err
  );
endinterface

// File: rtl/fun_dispatch.sv
// fun_dispatch: upstream sequencer for the fun core.
//   Buffers operand pairs in a DEPTH-entry FIFO, issues one fun_start pulse
//   per pair, waits for the core to drop busy, and returns the result with
//   the number of busy cycles seen in WAIT on a valid/ready sink.
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-low reset (also resets the fun core)
//   bus   - fun_dispatch_if.slave: in_* source, fun_* core link, out_* sink
// Parameters:
//   DEPTH    FIFO entries, power of two, >= 2
//   CNT_W    out_cycles width, saturating
//   MAX_WAIT WAIT-state cycle limit (timeout build only)
// Build option:
//   FUN_TIMEOUT_EN - when defined, an op whose core stays busy for MAX_WAIT
//   counted WAIT cycles is aborted: out_err=1, out_result=0,
//   out_cycles=MAX_WAIT. When undefined, WAIT is unbounded and out_err=0.
module fun_dispatch #(
  parameter int DEPTH    = 4,
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 2000
) (
  input  logic         clk,
  input  logic         rst,
  fun_dispatch_if.slave bus
);

  localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

  // Value reported in out_cycles on a timeout, clamped to the counter range.
  localparam logic [CNT_W-1:0] TMO_CYC =
    (CNT_W < 31 && MAX_WAIT >= (1 << CNT_W)) ? {CNT_W{1'b1}} : CNT_W'(MAX_WAIT);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_ARM   = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
  } pair_t;

  // ---------------------------------------------------------------- FIFO
  pair_t          mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    occ;
  logic           full, empty, push, pop;
  pair_t          head;

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       fa_q, fb_q;
  logic             ov_q;
  logic [10:0]      res_q;
  logic [CNT_W-1:0] cyc_q;
  logic             tmo_hit;

  assign full  = (occ == FULL_OCC);
  assign empty = (occ == '0);
  assign push  = bus.in_valid && !full;
  assign head  = mem[rd_ptr];

  // The head is consumed either from IDLE or in the same cycle a held result
  // is handed off, so back-to-back ops lose no cycle through IDLE.
  assign pop = !empty && ((state == S_IDLE) || (state == S_HOLD && bus.out_ready));

  // Storage needs no reset: occupancy decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{a: bus.in_a, b: bus.in_b};
  end

  // Pointers wrap naturally at AW bits because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   occ <= occ + (AW+1)'(1);
        2'b01:   occ <= occ - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  // ------------------------------------------------------------ timeout
`ifdef FUN_TIMEOUT_EN
  localparam int          TW       = $clog2(MAX_WAIT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(MAX_WAIT - 1);

  logic [TW-1:0] tmo_q;
  logic          err_q;

  // Separate from cnt_q so the limit still works when MAX_WAIT exceeds the
  // saturating out_cycles range. Hit on the MAX_WAIT-th busy cycle.
  assign tmo_hit = (state == S_WAIT) && bus.fun_busy && (tmo_q == TMO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else if (state == S_ARM) begin
      tmo_q <= '0;
    end else if (state == S_WAIT) begin
      if (!bus.fun_busy)  err_q <= 1'b0;
      else if (tmo_hit)   err_q <= 1'b1;
      else                tmo_q <= tmo_q + TW'(1);
    end
  end

  assign bus.out_err = err_q;
`else
  assign tmo_hit     = 1'b0;
  assign bus.out_err = 1'b0;
`endif

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      fa_q  <= '0;
      fb_q  <= '0;
      cnt_q <= '0;
      ov_q  <= 1'b0;
      res_q <= '0;
      cyc_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!empty) begin
            fa_q  <= head.a;
            fb_q  <= head.b;
            state <= S_START;
          end
        end
        S_START: state <= S_ARM;
        // The core may raise busy one cycle after start, so busy is not
        // trusted here; the count starts clean in WAIT.
        S_ARM: begin
          cnt_q <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (!bus.fun_busy) begin
            res_q <= bus.fun_result;
            cyc_q <= cnt_q;
            ov_q  <= 1'b1;
            state <= S_HOLD;
          end else if (tmo_hit) begin
            res_q <= '0;
            cyc_q <= TMO_CYC;
            ov_q  <= 1'b1;
            state <= S_HOLD;
          end else if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (bus.out_ready) begin
            ov_q <= 1'b0;
            if (!empty) begin
              fa_q  <= head.a;
              fb_q  <= head.b;
              state <= S_START;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = !full;
  assign bus.fun_a      = fa_q;
  assign bus.fun_b      = fb_q;
  assign bus.fun_start  = (state == S_START);
  assign bus.out_valid  = ov_q;
  assign bus.out_result = res_q;
  assign bus.out_cycles = cyc_q;

  // ------------------------------------------------------------- checks
  a_occ_bound: assert property (@(posedge clk) disable iff (!rst) occ <= FULL_OCC);
  a_start_pulse: assert property (@(posedge clk) disable iff (!rst)
    bus.fun_start |=> !bus.fun_start);

endmodule

// File: tb/tb_fun_dispatch.sv
module tb_fun_dispatch;
  localparam int DEPTH    = 4;
  localparam int CNT_W    = 4;
  localparam int MAX_WAIT = 8;
`ifdef FUN_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fun_dispatch_if #(.CNT_W(CNT_W)) bus ();

  fun_dispatch #(.DEPTH(DEPTH), .CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ------------------------------------------------------ reference model
  typedef struct { int a; int b; } pair_t;
  typedef struct { int res; int cyc; int err; } exp_t;

  pair_t pend_q[$];   // accepted, not yet started
  exp_t  exp_q[$];    // started, result not yet taken
  bit    inflight;
  int    n_start, n_out;
  int    last_res, last_cyc, last_err;

  int cfg_n    = -1;  // busy length per op (-1: random 1..7)
  int cfg_late = -1;  // core raises busy one cycle late (-1: random)
  bit stuck;          // core holds busy until released

  function automatic int cbrt8(input int v);
    int r = 0;
    while ((r + 1) * (r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  // Busy cycles visible in WAIT: the ARM cycle absorbs the first busy cycle
  // of an on-time core.
  function automatic exp_t model(input int a, input int b, input int n, input int late,
                                 input bit stk);
    exp_t e;
    int c;
    c = late ? n : ((n > 0) ? n - 1 : 0);
    if (stk || (TMO && c >= MAX_WAIT)) begin
      e.res = 0; e.cyc = MAX_WAIT; e.err = 1;
    end else begin
      e.res = (a * cbrt8(b)) % 2048;
      e.cyc = (c > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : c;
      e.err = 0;
    end
    return e;
  endfunction

  // Monitor + behavioural fun core: sample at negedge, drive core at posedge+1.
  bit   c_active, c_stuck_op, rst_s, hold_seen;
  int   c_wait, c_left, c_res, h_res, h_cyc, h_err;
  initial begin
    bus.fun_busy   = 1'b0;
    bus.fun_result = '0;
    forever begin
      @(negedge clk);
      rst_s = rst;
      if (!rst) begin
        pend_q.delete();
        exp_q.delete();
        inflight  = 1'b0;
        c_active  = 1'b0;
        hold_seen = 1'b0;
      end else begin
        if (hold_seen) begin
          chk("hold_valid", bus.out_valid, 1);
          chk("hold_res", bus.out_result, h_res);
          chk("hold_cyc", bus.out_cycles, h_cyc);
          chk("hold_err", bus.out_err, h_err);
        end
        if (bus.out_valid && bus.out_ready) begin
          hold_seen = 1'b0;
          chk("out_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("out_result", bus.out_result, e.res);
            chk("out_cycles", bus.out_cycles, e.cyc);
            chk("out_err", bus.out_err, e.err);
          end
          last_res = int'(bus.out_result);
          last_cyc = int'(bus.out_cycles);
          last_err = int'(bus.out_err);
          inflight = 1'b0;
          n_out++;
        end else if (bus.out_valid) begin
          hold_seen = 1'b1;
          h_res = int'(bus.out_result);
          h_cyc = int'(bus.out_cycles);
          h_err = int'(bus.out_err);
        end else begin
          hold_seen = 1'b0;
        end
        if (bus.fun_start) begin
          int n, late;
          pair_t p;
          n_start++;
          chk("one_in_flight", inflight, 0);
          inflight = 1'b1;
          chk("start_has_pair", pend_q.size() > 0, 1);
          p.a = 0; p.b = 0;
          if (pend_q.size() > 0) p = pend_q.pop_front();
          chk("fun_a", bus.fun_a, p.a);
          chk("fun_b", bus.fun_b, p.b);
          n    = (cfg_n >= 0) ? cfg_n : int'($urandom_range(1, 7));
          late = (cfg_late >= 0) ? cfg_late : int'($urandom_range(0, 1));
          exp_q.push_back(model(p.a, p.b, n, late, stuck));
          c_active   = 1'b1;
          c_stuck_op = stuck;
          c_wait     = late;
          c_left     = n;
          c_res      = (p.a * cbrt8(p.b)) % 2048;
        end
        if (bus.in_valid && bus.in_ready) begin
          pair_t q;
          q.a = int'(bus.in_a);
          q.b = int'(bus.in_b);
          pend_q.push_back(q);
        end
      end
      @(posedge clk); #1;
      if (!rst_s || !c_active) begin
        bus.fun_busy = 1'b0;
        if (!rst_s) bus.fun_result = '0;
      end else if (c_stuck_op) begin
        bus.fun_busy = stuck;
        if (!stuck) c_active = 1'b0;
      end else if (c_wait > 0) begin
        c_wait--;
        bus.fun_busy   = 1'b0;
        bus.fun_result = 11'($urandom_range(0, 2047));
      end else if (c_left > 0) begin
        c_left--;
        bus.fun_busy   = 1'b1;
        bus.fun_result = 11'($urandom_range(0, 2047));
      end else begin
        bus.fun_busy   = 1'b0;
        bus.fun_result = 11'(c_res);
        c_active       = 1'b0;
      end
    end
  end

  // --------------------------------------------------------------- stimulus
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int a, input int b);
    bit ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_a     = 8'(a);
    bus.in_b     = 8'(b);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("push_accepted", ok, 1);
  endtask

  task automatic drain();
    bit ok = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #2;
      if (pend_q.size() == 0 && exp_q.size() == 0 && !inflight &&
          !bus.out_valid && !bus.fun_start) begin ok = 1'b1; break; end
    end
    chk("drain", ok, 1);
    tick(1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, o0, lat, bad;
    bit ok, rdone;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
    tick(3);

    // reset state
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_fun_start", bus.fun_start, 0);
    chk("rst_fun_a", bus.fun_a, 0);
    chk("rst_fun_b", bus.fun_b, 0);
    chk("rst_out_result", bus.out_result, 0);
    chk("rst_out_cycles", bus.out_cycles, 0);
    chk("rst_out_err", bus.out_err, 0);
    rst = 1'b1;
    tick(2);

    // (5,27) -> 15, start at cycle 2 after push, one start pulse
    bus.out_ready = 1'b1; cfg_n = 3; cfg_late = 0;
    s0 = n_start; lat = -1;
    bus.in_valid = 1'b1; bus.in_a = 8'd5; bus.in_b = 8'd27;
    @(negedge clk);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int c = 1; c < 10; c++) begin
      @(negedge clk);
      if (bus.fun_start) begin lat = c; break; end
    end
    chk("start_latency", lat, 2);
    drain();
    chk("r5_27_res", last_res, 15);
    chk("r5_27_starts", n_start - s0, 1);

    // back-to-back pushes, results in order
    s0 = n_start; o0 = n_out; cfg_n = -1; cfg_late = -1;
    push(3, 64);
    push(9, 125);
    drain();
    chk("b2b_starts", n_start - s0, 2);
    chk("b2b_outs", n_out - o0, 2);
    chk("b2b_last", last_res, 45);

    // hold result with out_ready=0, fill FIFO, check stall and no new start
    s0 = n_start; o0 = n_out; cfg_n = 2; cfg_late = 1;
    bus.out_ready = 1'b0;
    push(5, 27);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #2;
      if (bus.out_valid) begin ok = 1'b1; break; end
    end
    chk("hold_seen_valid", ok, 1);
    chk("hold_res15", bus.out_result, 15);
    cfg_n = -1; cfg_late = -1;
    for (int i = 0; i < DEPTH; i++) push($urandom_range(0, 255), $urandom_range(0, 255));
    chk("fifo_filled", pend_q.size(), DEPTH);
    bus.in_valid = 1'b1; bus.in_a = 8'd2; bus.in_b = 8'd8;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.in_ready) bad++;
    end
    chk("full_stall", bad, 0);
    chk("no_start_in_hold", n_start - s0, 1);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("extra_accepted", ok, 1);
    drain();
    chk("full_outs", n_out - o0, DEPTH + 2);

    // reset during WAIT drops in-flight and queued ops
    cfg_n = 40; cfg_late = 0;
    push(9, 125);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.fun_start) begin ok = 1'b1; break; end
    end
    chk("rw_started", ok, 1);
    push(1, 1);
    tick(3);
    rst = 1'b0;
    #1;
    chk("rw_out_valid", bus.out_valid, 0);
    chk("rw_fun_start", bus.fun_start, 0);
    chk("rw_fun_a", bus.fun_a, 0);
    chk("rw_in_ready", bus.in_ready, 1);
    chk("rw_out_result", bus.out_result, 0);
    chk("rw_out_cycles", bus.out_cycles, 0);
    tick(2);
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.out_valid || bus.fun_start) bad++;
    end
    chk("rw_no_stale", bad, 0);

`ifdef FUN_TIMEOUT_EN
    // core stuck busy -> timeout, then a normal op
    stuck = 1'b1;
    push(200, 8);
    drain();
    chk("tmo_err", last_err, 1);
    chk("tmo_cycles", last_cyc, MAX_WAIT);
    chk("tmo_result", last_res, 0);
    stuck = 1'b0;
    tick(2);
    cfg_n = 3; cfg_late = 0;
    push(5, 27);
    drain();
    chk("post_tmo_res", last_res, 15);
    chk("post_tmo_err", last_err, 0);
`else
    // out_cycles saturates at all-ones
    cfg_n = 20; cfg_late = 1;
    push(7, 64);
    drain();
    chk("sat_cycles", last_cyc, (1 << CNT_W) - 1);
    chk("sat_res", last_res, 28);
`endif

    // randomized traffic with random sink backpressure
    cfg_n = -1; cfg_late = -1;
    s0 = n_start; o0 = n_out; rdone = 1'b0;
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          bus.in_valid = 1'b0;
          tick($urandom_range(0, 2));
          push($urandom_range(0, 255), $urandom_range(0, 255));
        end
        rdone = 1'b1;
      end
      begin
        while (!rdone) begin
          @(posedge clk); #1;
          bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();
    chk("rand_starts", n_start - s0, 30);
    chk("rand_outs", n_out - o0, 30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
